// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner with iterative MULTU (shift-add) and DIVU (restoring); WIDTH+1 cycles accept-to-done.
// Accepts only when idle; stall holds back HI/LO users while iterating, flush aborts without touching HI/LO.
module hilo_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hilo_rd,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MTHI  = 2'b10;
  localparam logic [1:0] OP_MTLO  = 2'b11;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic             accept;
  logic             last;

  // Shared datapath: MUL uses acc_hi:acc_lo as P and opnd as M;
  // DIV uses acc_hi as R, acc_lo as Q and opnd as D.
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic [WIDTH-1:0] acc_hi_nxt, acc_lo_nxt;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_rem;
  logic             div_ge;

  assign busy  = (state != IDLE);
  assign stall = busy & (start | hilo_rd);
  assign last  = (count == LAST);

  assign mul_sum   = {1'b0, acc_hi} + ({1'b0, opnd} & {(WIDTH+1){acc_lo[0]}});
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd});
  assign div_rem   = WIDTH'(div_shift - {1'b0, opnd});

  always_comb begin
    acc_hi_nxt = mul_sum[WIDTH:1];
    acc_lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};
    if (state == DIV) begin
      acc_hi_nxt = div_ge ? div_rem : div_shift[WIDTH-1:0];
      acc_lo_nxt = {acc_lo[WIDTH-2:0], div_ge};
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          accept = 1'b1;
          if (op == OP_MULTU)     state_nxt = MUL;
          else if (op == OP_DIVU) state_nxt = DIV;
        end
      end
      MUL, DIV: if (flush || last) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      count  <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      div0   <= 1'b0;
    end else begin
      done <= 1'b0;
      div0 <= 1'b0;
      if (accept) begin
        count <= '0;
        case (op)
          OP_MTHI: hi <= src_a;
          OP_MTLO: lo <= src_a;
          OP_MULTU: begin
            acc_hi <= '0;
            acc_lo <= src_b;
            opnd   <= src_a;
          end
          default: begin
            acc_hi <= '0;
            acc_lo <= src_a;
            opnd   <= src_b;
          end
        endcase
      end else if (busy) begin
        if (flush) begin
          count <= '0;
        end else begin
          acc_hi <= acc_hi_nxt;
          acc_lo <= acc_lo_nxt;
          count  <= count + 1'b1;
          if (last) begin
            hi    <= acc_hi_nxt;
            lo    <= acc_lo_nxt;
            done  <= 1'b1;
            div0  <= (state == DIV) && (opnd == '0);
            count <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Randomized + directed bench for hilo_muldiv_ctrl with a queue scoreboard fed by a plain-arithmetic model.
module tb_hilo_muldiv_ctrl;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MTHI  = 2'b10;
  localparam logic [1:0] OP_MTLO  = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        hilo_rd = 1'b0;
  logic        flush = 1'b0;
  logic        busy, stall, done, div0;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;

  // Expected completions: {div0, hi, lo}
  logic [64:0] exp_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  hilo_muldiv_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .hilo_rd(hilo_rd), .flush(flush), .busy(busy), .stall(stall), .done(done),
    .div0(div0), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [64:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (o == OP_MULTU) begin
      p = 64'(a) * 64'(b);
      return {1'b0, p};
    end
    if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
    return {1'b0, a % b, a / b};
  endfunction

  // Monitor: every done must match the oldest expected completion.
  logic [64:0] mon_e;
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no completion at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_hi", 64'(hi), 64'(mon_e[63:32]));
        check("done_lo", 64'(lo), 64'(mon_e[31:0]));
        check("done_div0", 64'(div0), 64'(mon_e[64]));
      end
    end
    if (rst_n && div0 && !done) begin
      total++;
      bad++;
      $display("FAIL div0_without_done: got div0=1 done=0 expected div0=0 at %0t", $time);
    end
  end

  // Called with the DUT idle (or in its done cycle), inputs driven at posedge+1.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int flush_at);
    logic [64:0] e;
    int n;
    e = ref_op(o, a, b);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    if (o == OP_MTHI || o == OP_MTLO) begin
      if (o == OP_MTHI) m_hi = a;
      else              m_lo = a;
      check("mt_hi", 64'(hi), 64'(m_hi));
      check("mt_lo", 64'(lo), 64'(m_lo));
      check("mt_busy", 64'(busy), 64'd0);
    end else if (flush_at >= 0) begin
      repeat (flush_at) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_busy", 64'(busy), 64'd0);
      check("flush_hi", 64'(hi), 64'(m_hi));
      check("flush_lo", 64'(lo), 64'(m_lo));
    end else begin
      exp_q.push_back(e);
      m_hi = e[63:32];
      m_lo = e[31:0];
      n = 0;
      while (busy && n < 40) begin
        n++;
        @(posedge clk); #1;
      end
      check("busy_len", 64'(n), 64'd32);
      check("done_at_end", 64'(done), 64'd1);
    end
  endtask

  initial begin
    int n;
    logic [64:0] e;
    #2;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset in the middle of a multiply
    run_op(OP_MTHI, 32'hAAAA_5555, 0, -1);
    run_op(OP_MTLO, 32'h1357_9BDF, 0, -1);
    start = 1'b1; op = OP_MULTU; src_a = 32'd1234; src_b = 32'd5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    check("midrst_no_done", 64'(n), 64'd0);

    // Boundary arithmetic
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    check("mul_max_hi", 64'(hi), 64'hFFFF_FFFE);
    check("mul_max_lo", 64'(lo), 64'h1);
    run_op(OP_DIVU, 32'd100, 32'd7, -1);
    check("div_100_7_lo", 64'(lo), 64'd14);
    check("div_100_7_hi", 64'(hi), 64'd2);
    run_op(OP_DIVU, 32'h8000_0000, 32'd3, -1);
    check("div_big_lo", 64'(lo), 64'h2AAA_AAAA);
    check("div_big_hi", 64'(hi), 64'd2);
    run_op(OP_DIVU, 32'd5, 32'd0, -1);
    check("div0_lo", 64'(lo), 64'hFFFF_FFFF);
    check("div0_hi", 64'(hi), 64'd5);

    // Flush mid-multiply, flush in idle, flush beating start
    run_op(OP_MTHI, 32'h1234, 0, -1);
    run_op(OP_MULTU, 32'd3, 32'd4, 9);
    check("flush_keep_hi", 64'(hi), 64'h1234);
    repeat (5) @(posedge clk);
    #1 start = 1'b1; op = OP_MTHI; src_a = 32'hDEAD; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_beats_start", 64'(hi), 64'h1234);
    run_op(OP_MULTU, 32'd3, 32'd4, -1);
    check("mul_3_4_hi", 64'(hi), 64'd0);
    check("mul_3_4_lo", 64'(lo), 64'd12);
    run_op(OP_DIVU, 32'd77, 32'd9, 31);

    // Stall behaviour and an MTLO held off until the divide completes
    e = ref_op(OP_DIVU, 32'hCAFE_BABE, 32'd1000);
    start = 1'b1; op = OP_DIVU; src_a = 32'hCAFE_BABE; src_b = 32'd1000;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    hilo_rd = 1'b1; #1;
    check("stall_rd", 64'(stall), 64'd1);
    hilo_rd = 1'b0; #1;
    check("stall_quiet", 64'(stall), 64'd0);
    start = 1'b1; op = OP_MTLO; src_a = 32'hC0FF_EE00; #1;
    n = 0;
    while (busy && n < 40) begin
      check("stall_start", 64'(stall), 64'd1);
      check("held_lo", 64'(lo), 64'(m_lo));
      n++;
      @(posedge clk); #1;
    end
    check("held_busy_len", 64'(n), 64'd32);
    @(posedge clk); #1;
    start = 1'b0;
    m_hi = e[63:32];
    m_lo = 32'hC0FF_EE00;
    check("mtlo_after_hi", 64'(hi), 64'(m_hi));
    check("mtlo_after_lo", 64'(lo), 64'(m_lo));

    // Randomized mix
    for (int i = 0; i < 30; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      int          sel, fa;
      ro  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      sel = $urandom_range(0, 3);
      rb  = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 15)) : $urandom;
      fa  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 31) : -1;
      run_op(ro, ra, rb, fa);
    end

    repeat (3) @(posedge clk);
    #1 check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
